turf_udp_hsk_spi_bridge: RTL and testbench

TURF_UDP_HSK_SPI_BRIDGE -- requirements
Module: turf_udp_hsk_spi_bridge

---
 rtl/turf_udp_hsk_pkg.sv | 35 +++
 rtl/turf_udp_hsk_spi_rx.sv | 162 ++++++++++++++++
 rtl/turf_udp_hsk_spi_bridge.sv | 141 ++++++++++++++
 tb/tb_turf_udp_hsk_spi_bridge.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/turf_udp_hsk_pkg.sv
// Shared types and constants for the TURF UDP housekeeping SPI bridge.
// Header layout, count-entry format and the arbiter state encoding.
package turf_udp_hsk_pkg;

  localparam int UDP_HDR_BYTES = 8;
  localparam int CNT_W         = 12;
  localparam int TRUNC_BIT     = 12;
  localparam int HDR_LEN_LSB   = 0;
  localparam int HDR_PORT_LSB  = 16;
  localparam int HDR_IP_LSB    = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA
  } arb_state_e;

  typedef struct packed {
    logic             trunc;
    logic [CNT_W-1:0] len;
  } cnt_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } dword_t;

  function automatic logic [7:0] keep_mask(input logic [3:0] n);
    logic [8:0] m;
    m = (9'h1 << n) - 9'h1;
    return m[7:0];
  endfunction

endpackage

// File: rtl/turf_udp_hsk_spi_rx.sv
// One SPI write channel: synchronizers, deserializer, little-endian
// packer, payload word FIFO and per-packet count FIFO.
module turf_udp_hsk_spi_rx
  import turf_udp_hsk_pkg::*;
#(
  parameter int SPI_MODE   = 0,
  parameter int MAX_BYTES  = 1024,
  parameter int FIFO_WORDS = 512
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   sclk_i,
  input  logic   mosi_i,
  input  logic   cs_b_i,
  output dword_t dat_o,
  output logic   dat_valid_o,
  input  logic   dat_pop_i,
  output cnt_t   cnt_o,
  output logic   cnt_valid_o,
  input  logic   cnt_pop_i
);

  localparam int AW = $clog2(FIFO_WORDS);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(FIFO_WORDS);
  localparam logic [AW:0] LVL_ROOM = (AW+1)'(FIFO_WORDS - 1);
  localparam logic [AW:0] ONE      = (AW+1)'(1);
  localparam bit SAMPLE_RISE = (SPI_MODE == 0) || (SPI_MODE == 3);

  // [1:0] synchronize, [2] holds the previous synchronized value
  logic [2:0] sclk_q, cs_q;
  logic [1:0] mosi_q;

  logic             armed_q, armed_d;
  logic [2:0]       bits_q, bits_d;
  logic [6:0]       shift_q, shift_d;
  logic [63:0]      word_q, word_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic [CNT_W-1:0] nbytes_q, nbytes_d;
  logic             trunc_q, trunc_d;

  dword_t      mem [FIFO_WORDS];
  logic [AW:0] wp_q, rp_q, used;
  cnt_t        cmem [16];
  logic [4:0]  cwp_q, crp_q;
  logic        cfull;

  logic   samp, cs_rise, byte_ok, push, cpush;
  logic [7:0] byte_v;
  dword_t push_w;
  cnt_t   cpush_e;

  assign samp = SAMPLE_RISE ? (sclk_q[1] & ~sclk_q[2])
                            : (~sclk_q[1] & sclk_q[2]);
  assign cs_rise = cs_q[1] & ~cs_q[2];
  assign used    = wp_q - rp_q;
  assign cfull   = (cwp_q - crp_q) == 5'd16;

  always_comb begin
    armed_d  = armed_q | cs_q[1];
    bits_d   = bits_q;
    shift_d  = shift_q;
    word_d   = word_q;
    wcnt_d   = wcnt_q;
    nbytes_d = nbytes_q;
    trunc_d  = trunc_q;
    byte_v   = {shift_q, mosi_q[1]};
    byte_ok  = 1'b0;
    push     = 1'b0;
    push_w   = '0;
    cpush    = 1'b0;
    cpush_e  = '0;
    if (cs_q[1]) begin
      bits_d = '0;
    end else if (armed_q && samp) begin
      shift_d = byte_v[6:0];
      bits_d  = bits_q + 3'd1;
      byte_ok = (bits_q == 3'd7);
    end
    if (byte_ok) begin
      if (int'(nbytes_q) >= MAX_BYTES) begin
        trunc_d = 1'b1;
      end else begin
        // a full word is held back until we know whether it is the last
        if (wcnt_q == 4'd8) begin
          if (used < LVL_ROOM) begin
            push   = 1'b1;
            push_w = '{data: word_q, keep: 8'hFF, last: 1'b0};
          end else begin
            nbytes_d = nbytes_q - 12'd8;
            trunc_d  = 1'b1;
          end
          word_d = '0;
          wcnt_d = '0;
        end
        word_d[{wcnt_d[2:0], 3'b000} +: 8] = byte_v;
        wcnt_d   = wcnt_d + 4'd1;
        nbytes_d = nbytes_d + 12'd1;
      end
    end
    if (cs_rise && armed_q) begin
      if (wcnt_q != 4'd0) begin
        push    = (used != LVL_FULL);
        push_w  = '{data: word_q, keep: keep_mask(wcnt_q), last: 1'b1};
        cpush   = 1'b1;
        cpush_e = '{trunc: trunc_q,
                    len: nbytes_q + CNT_W'(UDP_HDR_BYTES)};
      end
      word_d   = '0;
      wcnt_d   = '0;
      nbytes_d = '0;
      trunc_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q   <= '0;
      cs_q     <= '0;
      mosi_q   <= '0;
      armed_q  <= 1'b0;
      bits_q   <= '0;
      shift_q  <= '0;
      word_q   <= '0;
      wcnt_q   <= '0;
      nbytes_q <= '0;
      trunc_q  <= 1'b0;
      wp_q     <= '0;
      rp_q     <= '0;
      cwp_q    <= '0;
      crp_q    <= '0;
    end else begin
      sclk_q   <= {sclk_q[1:0], sclk_i};
      cs_q     <= {cs_q[1:0], cs_b_i};
      mosi_q   <= {mosi_q[0], mosi_i};
      armed_q  <= armed_d;
      bits_q   <= bits_d;
      shift_q  <= shift_d;
      word_q   <= word_d;
      wcnt_q   <= wcnt_d;
      nbytes_q <= nbytes_d;
      trunc_q  <= trunc_d;
      if (push) wp_q <= wp_q + ONE;
      if (dat_pop_i && dat_valid_o) rp_q <= rp_q + ONE;
      if (cpush && !cfull) cwp_q <= cwp_q + 5'd1;
      if (cnt_pop_i && cnt_valid_o) crp_q <= crp_q + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp_q[AW-1:0]] <= push_w;
    if (cpush && !cfull) cmem[cwp_q[3:0]] <= cpush_e;
  end

  assign dat_o       = mem[rp_q[AW-1:0]];
  assign dat_valid_o = (wp_q != rp_q);
  assign cnt_o       = cmem[crp_q[3:0]];
  assign cnt_valid_o = (cwp_q != crp_q);

  a_cnt_ovf: assert property (
    @(posedge clk) disable iff (!rst_n) !(cpush && cfull));

endmodule

// File: rtl/turf_udp_hsk_spi_bridge.sv
// NCHAN SPI write channels merged into one UDP header/payload stream
// by a round-robin arbiter that drains one whole packet at a time.
module turf_udp_hsk_spi_bridge
  import turf_udp_hsk_pkg::*;
#(
  parameter int NCHAN      = 2,
  parameter int SPI_MODE   = 0,
  parameter int MAX_BYTES  = 1024,
  parameter int FIFO_WORDS = 512,
  parameter     DEBUG      = "TRUE"
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [NCHAN-1:0] sclk,
  input  logic [NCHAN-1:0] mosi,
  input  logic [NCHAN-1:0] cs_b,
  input  logic [31:0]      ip_i,
  input  logic [15:0]      port_base_i,
  output logic [63:0]      m_udphdr_tdata,
  output logic             m_udphdr_tvalid,
  input  logic             m_udphdr_tready,
  output logic [63:0]      m_udpdata_tdata,
  output logic [7:0]       m_udpdata_tkeep,
  output logic             m_udpdata_tlast,
  output logic             m_udpdata_tvalid,
  input  logic             m_udpdata_tready
);

  localparam int GW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  dword_t           dat [NCHAN];
  cnt_t             cnt [NCHAN];
  logic [NCHAN-1:0] dat_v, dat_pop, cnt_v, cnt_pop;

  for (genvar c = 0; c < NCHAN; c++) begin : g_ch
    turf_udp_hsk_spi_rx #(
      .SPI_MODE  (SPI_MODE),
      .MAX_BYTES (MAX_BYTES),
      .FIFO_WORDS(FIFO_WORDS)
    ) u_rx (
      .clk        (aclk),
      .rst_n      (aresetn),
      .sclk_i     (sclk[c]),
      .mosi_i     (mosi[c]),
      .cs_b_i     (cs_b[c]),
      .dat_o      (dat[c]),
      .dat_valid_o(dat_v[c]),
      .dat_pop_i  (dat_pop[c]),
      .cnt_o      (cnt[c]),
      .cnt_valid_o(cnt_v[c]),
      .cnt_pop_i  (cnt_pop[c])
    );
  end

  arb_state_e    st_q, st_d;
  logic [GW-1:0] gnt_q, gnt_d, ptr_q, ptr_d, sel;
  logic          found, hv, dv;
  logic [63:0]   hdr;
  int            idx;

  // ptr_q is the first channel to search; it moves past each grant
  always_comb begin
    sel   = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % NCHAN;
      if (cnt_v[idx]) begin
        sel   = GW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    st_d    = st_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    hv      = 1'b0;
    dv      = 1'b0;
    cnt_pop = '0;
    dat_pop = '0;
    unique case (st_q)
      ST_IDLE: begin
        if (found) begin
          gnt_d = sel;
          ptr_d = GW'((int'(sel) + 1) % NCHAN);
          st_d  = ST_HDR;
        end
      end
      ST_HDR: begin
        hv = cnt_v[gnt_q];
        if (hv && m_udphdr_tready) begin
          cnt_pop[gnt_q] = 1'b1;
          st_d           = ST_DATA;
        end
      end
      ST_DATA: begin
        dv = dat_v[gnt_q];
        if (dv && m_udpdata_tready) begin
          dat_pop[gnt_q] = 1'b1;
          if (dat[gnt_q].last) st_d = ST_IDLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      st_q  <= ST_IDLE;
      gnt_q <= '0;
      ptr_q <= '0;
    end else begin
      st_q  <= st_d;
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    hdr = '0;
    hdr[HDR_IP_LSB +: 32]     = ip_i;
    hdr[HDR_PORT_LSB +: 16]   = port_base_i + 16'(gnt_q);
    hdr[TRUNC_BIT]            = cnt[gnt_q].trunc;
    hdr[HDR_LEN_LSB +: CNT_W] = cnt[gnt_q].len;
  end

  assign m_udphdr_tvalid  = hv;
  assign m_udphdr_tdata   = hv ? hdr : '0;
  assign m_udpdata_tvalid = dv;
  assign m_udpdata_tdata  = dv ? dat[gnt_q].data : '0;
  assign m_udpdata_tkeep  = dv ? dat[gnt_q].keep : '0;
  assign m_udpdata_tlast  = dv ? dat[gnt_q].last : 1'b0;

  if (DEBUG == "TRUE") begin : g_dbg
    a_excl: assert property (@(posedge aclk) disable iff (!aresetn)
      !(m_udphdr_tvalid && m_udpdata_tvalid));
  end

endmodule

// File: tb/tb_turf_udp_hsk_spi_bridge.sv
// Directed-vector bench for turf_udp_hsk_spi_bridge (2 channels, mode 0,
// 16-byte payload cap) with a stream monitor and multi-cycle sequences.
module tb_turf_udp_hsk_spi_bridge;

  localparam int NCHAN = 2;
  localparam logic [31:0] IP = 32'hC0A8_0102;
  localparam logic [15:0] PB = 16'hFFFF;

  typedef struct {
    int          ch;
    int          nbits;
    logic [7:0]  base;
    int          len;
    bit          trunc;
    int          words;
    logic [7:0]  keep;
    logic [63:0] w0;
  } vec_t;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic [NCHAN-1:0] sclk = '0;
  logic [NCHAN-1:0] mosi = '0;
  logic [NCHAN-1:0] cs_b = '1;
  logic [63:0]      hdata;
  logic             hvalid;
  logic             hready = 1'b1;
  logic [63:0]      ddata;
  logic [7:0]       dkeep;
  logic             dlast;
  logic             dvalid;
  logic             dready = 1'b1;

  turf_udp_hsk_spi_bridge #(
    .NCHAN     (NCHAN),
    .SPI_MODE  (0),
    .MAX_BYTES (16),
    .FIFO_WORDS(16),
    .DEBUG     ("TRUE")
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .sclk            (sclk),
    .mosi            (mosi),
    .cs_b            (cs_b),
    .ip_i            (IP),
    .port_base_i     (PB),
    .m_udphdr_tdata  (hdata),
    .m_udphdr_tvalid (hvalid),
    .m_udphdr_tready (hready),
    .m_udpdata_tdata (ddata),
    .m_udpdata_tkeep (dkeep),
    .m_udpdata_tlast (dlast),
    .m_udpdata_tvalid(dvalid),
    .m_udpdata_tready(dready)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad = 0;

  logic [63:0] hq [$];
  logic [63:0] dq [$];
  logic [7:0]  kq [$];
  bit          lq [$];
  int          evq [$];
  int          pkts = 0;
  int          overlap = 0;
  int          unstable = 0;
  logic        ph_v = 0, ph_r = 0, pd_v = 0, pd_r = 0;
  logic [63:0] ph_d, pd_d;
  logic [7:0]  pd_k;
  logic        pd_l;

  logic [7:0]  txb [NCHAN][32];
  vec_t        vt [7];

  always @(negedge aclk) begin
    if (aresetn) begin
      if (hvalid && dvalid) overlap++;
      if (ph_v && !ph_r && (!hvalid || hdata !== ph_d)) unstable++;
      if (pd_v && !pd_r && (!dvalid || ddata !== pd_d ||
          dkeep !== pd_k || dlast !== pd_l)) unstable++;
      if (hvalid && hready) begin
        hq.push_back(hdata);
        evq.push_back(0);
      end
      if (dvalid && dready) begin
        dq.push_back(ddata);
        kq.push_back(dkeep);
        lq.push_back(dlast);
        evq.push_back(1);
        if (dlast) pkts++;
      end
    end
    ph_v = aresetn & hvalid;
    ph_r = hready;
    ph_d = hdata;
    pd_v = aresetn & dvalid;
    pd_r = dready;
    pd_d = ddata;
    pd_k = dkeep;
    pd_l = dlast;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] hexp(input int ch, input bit tr,
                                       input int len);
    return {IP, PB + 16'(ch), 3'b000, tr, 12'(len)};
  endfunction

  function automatic logic [63:0] kmask(input logic [7:0] k);
    logic [63:0] m;
    for (int j = 0; j < 8; j++) m[j*8 +: 8] = {8{k[j]}};
    return m;
  endfunction

  task automatic clr();
    hq.delete();
    dq.delete();
    kq.delete();
    lq.delete();
    evq.delete();
    pkts = 0;
  endtask

  task automatic fill(input int ch, input logic [7:0] base);
    for (int k = 0; k < 32; k++) txb[ch][k] = base + 8'(k);
  endtask

  task automatic spi_xfer(input logic [NCHAN-1:0] m, input int nbits);
    for (int c = 0; c < NCHAN; c++) if (m[c]) cs_b[c] = 1'b0;
    #40;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < NCHAN; c++)
        if (m[c]) mosi[c] = txb[c][b/8][7 - (b % 8)];
      #40;
      for (int c = 0; c < NCHAN; c++) if (m[c]) sclk[c] = 1'b1;
      #40;
      for (int c = 0; c < NCHAN; c++) if (m[c]) sclk[c] = 1'b0;
    end
    #40;
    for (int c = 0; c < NCHAN; c++) if (m[c]) cs_b[c] = 1'b1;
    #80;
  endtask

  task automatic wait_pkts(input int n, input string nm);
    int cyc;
    cyc = 0;
    while (pkts < n && cyc < 3000) begin
      @(posedge aclk);
      cyc++;
    end
    total++;
    if (pkts < n) begin
      bad++;
      $display("FAIL %s_timeout: pkts=%0d want %0d", nm, pkts, n);
    end
  endtask

  task automatic rst_chk(input string nm);
    chk({nm, "_hvalid"}, 64'(hvalid), 64'd0);
    chk({nm, "_dvalid"}, 64'(dvalid), 64'd0);
    chk({nm, "_tkeep"}, 64'(dkeep), 64'd0);
    chk({nm, "_tlast"}, 64'(dlast), 64'd0);
  endtask

  initial begin
    logic [7:0] ek;
    int         nw;

    vt[0] = '{0, 24,  8'h01, 11, 1'b0, 1, 8'h07, 64'h0000_0000_0003_0201};
    vt[1] = '{0, 128, 8'h10, 24, 1'b0, 2, 8'hFF, 64'h1716_1514_1312_1110};
    vt[2] = '{0, 160, 8'h20, 24, 1'b1, 2, 8'hFF, 64'h2726_2524_2322_2120};
    vt[3] = '{0, 11,  8'hA5, 9,  1'b0, 1, 8'h01, 64'h0000_0000_0000_00A5};
    vt[4] = '{1, 64,  8'h40, 16, 1'b0, 1, 8'hFF, 64'h4746_4544_4342_4140};
    vt[5] = '{0, 5,   8'h33, 0,  1'b0, 0, 8'h00, 64'h0};
    vt[6] = '{1, 72,  8'h50, 17, 1'b0, 2, 8'h01, 64'h5756_5554_5352_5150};

    repeat (3) @(posedge aclk);
    #2;
    rst_chk("rst0");
    aresetn = 1'b1;
    repeat (10) @(posedge aclk);

    for (int i = 0; i < 7; i++) begin
      clr();
      fill(vt[i].ch, vt[i].base);
      spi_xfer(NCHAN'(1 << vt[i].ch), vt[i].nbits);
      nw = vt[i].words;
      if (nw == 0) begin
        repeat (200) @(posedge aclk);
        chk($sformatf("v%0d_nohdr", i), 64'(hq.size()), 64'd0);
        chk($sformatf("v%0d_nodata", i), 64'(dq.size()), 64'd0);
      end else begin
        wait_pkts(1, $sformatf("v%0d", i));
        chk($sformatf("v%0d_nhdr", i), 64'(hq.size()), 64'd1);
        if (hq.size() > 0)
          chk($sformatf("v%0d_hdr", i), hq[0],
              hexp(vt[i].ch, vt[i].trunc, vt[i].len));
        chk($sformatf("v%0d_words", i), 64'(dq.size()), 64'(nw));
        if (dq.size() == nw) begin
          for (int w = 0; w < nw; w++) begin
            ek = (w == nw - 1) ? vt[i].keep : 8'hFF;
            chk($sformatf("v%0d_keep%0d", i, w), 64'(kq[w]), 64'(ek));
            chk($sformatf("v%0d_last%0d", i, w), 64'(lq[w]),
                64'(w == nw - 1));
          end
          ek = (nw == 1) ? vt[i].keep : 8'hFF;
          chk($sformatf("v%0d_w0", i), dq[0] & kmask(ek), vt[i].w0);
        end
      end
    end

    // both channels close on the same cycle: ch0 drains first, whole
    clr();
    fill(0, 8'h60);
    fill(1, 8'h70);
    spi_xfer(2'b11, 64);
    wait_pkts(2, "dual");
    chk("dual_nev", 64'(evq.size()), 64'd4);
    if (evq.size() == 4)
      chk("dual_order", {evq[0][0], evq[1][0], evq[2][0], evq[3][0]},
          64'b0101);
    if (hq.size() == 2 && dq.size() == 2) begin
      chk("dual_h0", hq[0], hexp(0, 1'b0, 16));
      chk("dual_h1", hq[1], hexp(1, 1'b0, 16));
      chk("dual_d0", dq[0], 64'h6766_6564_6362_6160);
      chk("dual_d1", dq[1], 64'h7776_7574_7372_7170);
    end else begin
      chk("dual_counts", 64'(hq.size() * 16 + dq.size()), 64'h22);
    end

    // reset in the middle of a transfer discards it
    clr();
    fill(0, 8'h90);
    fork
      spi_xfer(2'b01, 32);
      begin
        #1000;
        aresetn = 1'b0;
        #2;
        rst_chk("rst_mid");
        #30;
        aresetn = 1'b1;
      end
    join
    repeat (300) @(posedge aclk);
    chk("abort_nohdr", 64'(hq.size()), 64'd0);
    chk("abort_nodata", 64'(dq.size()), 64'd0);
    fill(0, 8'hB0);
    spi_xfer(2'b01, 24);
    wait_pkts(1, "recover");
    if (hq.size() > 0) chk("recover_hdr", hq[0], hexp(0, 1'b0, 11));
    if (dq.size() > 0)
      chk("recover_d0", dq[0] & kmask(8'h07), 64'h00B2_B1B0);

    // backpressure on header then on data
    clr();
    @(posedge aclk);
    #1;
    hready = 1'b0;
    dready = 1'b0;
    fill(0, 8'hC0);
    spi_xfer(2'b01, 128);
    repeat (100) @(posedge aclk);
    #2;
    chk("bp_hvalid", 64'(hvalid), 64'd1);
    chk("bp_hdata", hdata, hexp(0, 1'b0, 24));
    chk("bp_dvalid_idle", 64'(dvalid), 64'd0);
    @(posedge aclk);
    #1;
    hready = 1'b1;
    @(posedge aclk);
    #1;
    hready = 1'b0;
    repeat (100) @(posedge aclk);
    #2;
    chk("bp_dvalid", 64'(dvalid), 64'd1);
    chk("bp_ddata", ddata, 64'hC7C6_C5C4_C3C2_C1C0);
    chk("bp_dlast", 64'(dlast), 64'd0);
    chk("bp_hvalid_off", 64'(hvalid), 64'd0);
    @(posedge aclk);
    #1;
    dready = 1'b1;
    hready = 1'b1;
    wait_pkts(1, "bp");
    chk("bp_words", 64'(dq.size()), 64'd2);
    if (dq.size() == 2) begin
      chk("bp_d1", dq[1], 64'hCFCE_CDCC_CBCA_C9C8);
      chk("bp_l1", 64'(lq[1]), 64'd1);
      chk("bp_k1", 64'(kq[1]), 64'hFF);
    end

    chk("overlap", 64'(overlap), 64'd0);
    chk("stable", 64'(unstable), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
